spi_byte_shifter: RTL and testbench

Byte-to-serial SPI engine that sits directly downstream of the APB-to-SPI NOR flash controller. It accepts command, address and data bytes over a valid/ready byte interface and shifts them MSB-first onto a mode-0 SPI bus (SCK idle low). It captures the flash's MISO bits into returned bytes and owns chip-select framing across multi-byte transactions. The controller drives the byte stream; this block produces the physical SPI pins.

---
 rtl/spi_byte_shifter.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_byte_shifter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter
//
// Byte-to-serial SPI master engine, SPI mode 0 (SCK idles low, MISO sampled
// on the rising edge, MOSI launched on the falling edge). Bytes arrive over a
// valid/ready handshake and are shifted out MSB first. The byte captured from
// MISO during the same eight clocks is returned on rx_data with a one-cycle
// rx_valid pulse. Chip select stays asserted across bytes until a byte
// flagged tx_last completes. CS is then released after a hold time and kept
// high for a gap time before the next transaction can start.
//
// Parameters
//   CLK_DIV   SCK half-period in p_clk cycles (>= 1).
//
// Ports
//   p_clk      in   system clock, rising edge
//   p_reset    in   synchronous active-high reset
//   tx_valid   in   tx_data / tx_last valid
//   tx_ready   out  byte can be accepted (IDLE or WAIT)
//   tx_data    in   byte to send, MSB first
//   tx_last    in   byte closes the transaction
//   rx_valid   out  one-cycle pulse, rx_data is the byte just received
//   rx_data    out  received byte, first sampled bit in bit 7
//   busy       out  engine not idle
//   spi_sck    out  SPI clock
//   spi_cs_n   out  chip select, active low
//   spi_mosi   out  serial data to flash
//   spi_miso   in   serial data from flash
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    // SCK edge index within a byte: odd values are rises, even values falls.
    // Edge 15 is the 8th rise, edge 16 the 8th fall; the wrap seen while the
    // index is 16 closes the byte.
    localparam logic [4:0] EDGE_RISE8 = 5'd15;
    localparam logic [4:0] EDGE_DONE  = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       edge_q, edge_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;

    // Datapath registers; only meaningful after an accept loads them.
    // Bit 7 of the byte goes straight to MOSI at accept, so the tx
    // register only carries the remaining seven bits.
    logic [6:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic             last_q, last_d;

    logic             half_done;
    logic             accept;

    assign half_done = (cnt_q == CNT_MAX);
    // tx_ready_q is only high in IDLE/WAIT, so it alone qualifies accept.
    assign accept    = tx_valid && tx_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        last_d     = last_q;

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (accept) begin
                    tx_sr_d = tx_data[6:0];
                    last_d  = tx_last;
                    mosi_d  = tx_data[7];
                    cnt_d   = '0;
                    edge_d  = '0;
                    cs_n_d  = 1'b0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                // The end of the setup half-period doubles as the first
                // rising SCK edge, so MISO bit 7 is captured here.
                if (half_done) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[6:0], spi_miso};
                    edge_d  = 5'd1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (half_done) begin
                    cnt_d  = '0;
                    edge_d = edge_q + 5'd1;
                    if (edge_q == EDGE_DONE) begin
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                        state_d    = last_q ? ST_HOLD : ST_WAIT;
                    end else if (!sck_q) begin
                        sck_d   = 1'b1;
                        rx_sr_d = {rx_sr_q[6:0], spi_miso};
                    end else begin
                        sck_d = 1'b0;
                        // After the 8th rise MOSI keeps bit 0 so the line
                        // stays stable through WAIT.
                        if (edge_q != EDGE_RISE8) begin
                            mosi_d  = tx_sr_q[6];
                            tx_sr_d = {tx_sr_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (half_done) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
            end
        endcase

        // Registered from the next state so these outputs line up with the
        // state they describe.
        tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge p_clk) begin
        tx_sr_q <= tx_sr_d;
        rx_sr_q <= rx_sr_d;
        last_q  <= last_d;
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Testbench for spi_byte_shifter. Instance A runs with CLK_DIV=2 and either
// loops MOSI back to MISO or plays a simple flash model; instance B runs with
// CLK_DIV=1 and MISO tied high. Expected MOSI bytes and rx bytes for A are
// queued when a byte is issued and consumed by an independent monitor.
module tb_spi_byte_shifter;

    logic p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    logic p_reset = 1'b1;

    logic       a_tx_valid = 1'b0, a_tx_ready, a_tx_last = 1'b0;
    logic [7:0] a_tx_data = 8'h00, a_rx_data;
    logic       a_rx_valid, a_busy, a_sck, a_cs_n, a_mosi, a_miso;

    logic       b_tx_valid = 1'b0, b_tx_ready, b_tx_last = 1'b0;
    logic [7:0] b_tx_data = 8'h00, b_rx_data;
    logic       b_rx_valid, b_busy, b_sck, b_cs_n, b_mosi;

    logic       use_flash = 1'b0;
    logic [7:0] flash_byte = 8'h00;
    logic [2:0] rise_cnt = 3'd0;

    // Flash model shifts out flash_byte MSB first, one bit per SCK rise.
    assign a_miso = use_flash ? flash_byte[~rise_cnt] : a_mosi;

    spi_byte_shifter #(.CLK_DIV(2)) u_dut_a (
        .p_clk(p_clk), .p_reset(p_reset),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data), .tx_last(a_tx_last),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy),
        .spi_sck(a_sck), .spi_cs_n(a_cs_n), .spi_mosi(a_mosi), .spi_miso(a_miso)
    );

    spi_byte_shifter #(.CLK_DIV(1)) u_dut_b (
        .p_clk(p_clk), .p_reset(p_reset),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data), .tx_last(b_tx_last),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy),
        .spi_sck(b_sck), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(1'b1)
    );

    int cyc = 0;
    always @(posedge p_clk) cyc <= cyc + 1;

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard monitor for instance A ----------------
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] mosi_cap = 8'h00;
    logic       sck_prev = 1'b0, mosi_prev = 1'b0, cs_prev = 1'b1;
    int         total_rises = 0, rxv_count = 0, cs_rise_cnt = 0, mosi_viol = 0;

    always @(negedge p_clk) begin
        if (p_reset) begin
            rise_cnt = 3'd0;
        end else begin
            if (a_sck && (a_mosi !== mosi_prev)) mosi_viol++;
            if (a_sck && !sck_prev) begin
                mosi_cap = {mosi_cap[6:0], a_mosi};
                total_rises++;
                rise_cnt = rise_cnt + 3'd1;
                if (rise_cnt == 3'd0) begin
                    if (exp_tx.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL mosi_byte: got %02h with no byte expected", mosi_cap);
                    end else begin
                        check("mosi_byte", mosi_cap, exp_tx.pop_front());
                    end
                end
            end
            if (a_rx_valid) begin
                rxv_count++;
                if (exp_rx.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL rx_byte: got %02h with no byte expected", a_rx_data);
                end else begin
                    check("rx_byte", a_rx_data, exp_rx.pop_front());
                end
            end
            if (a_cs_n && !cs_prev) cs_rise_cnt++;
        end
        sck_prev  = a_sck;
        mosi_prev = a_mosi;
        cs_prev   = a_cs_n;
    end

    // ---------------- stimulus helpers ----------------
    // Returns t = cycle in which valid and ready are both high; the accept
    // edge closes that cycle, so cs_n falls in cycle t+1.
    task automatic send_a(input logic [7:0] d, input logic l, input logic [7:0] fb,
                          input bit hold, output int t);
        int n;
        n = 0;
        @(negedge p_clk);
        while (!a_tx_ready && n < 400) begin
            @(negedge p_clk);
            n++;
        end
        if (!a_tx_ready) begin
            chk_cnt++;
            $display("FAIL send_timeout: tx_ready stayed %0b, required 1", a_tx_ready);
        end
        flash_byte = fb;
        a_tx_data  = d;
        a_tx_last  = l;
        a_tx_valid = 1'b1;
        exp_tx.push_back(d);
        exp_rx.push_back(use_flash ? fb : d);
        t = cyc;
        @(posedge p_clk);
        #1;
        if (!hold) a_tx_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input string name);
        int n;
        n = 0;
        @(negedge p_clk);
        while (!(a_tx_ready && !a_busy) && n < 400) begin
            @(negedge p_clk);
            n++;
        end
        if (!(a_tx_ready && !a_busy)) begin
            chk_cnt++;
            $display("FAIL %s_idle_timeout: busy=%0b tx_ready=%0b, required 0/1", name, a_busy, a_tx_ready);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t, k, rxv_k, rxv_n, cs_k, rdy_k, r0, c0, v0, bp_bad, n;
        logic lp;
        logic [7:0] rxd;
        int rises[$];

        // Reset state
        repeat (3) @(posedge p_clk);
        @(negedge p_clk);
        check("rst_cs_n", a_cs_n, 1'b1);
        check("rst_sck", a_sck, 1'b0);
        check("rst_mosi", a_mosi, 1'b0);
        check("rst_rx_valid", a_rx_valid, 1'b0);
        check("rst_rx_data", a_rx_data, 8'h00);
        check("rst_busy", a_busy, 1'b0);
        check("rst_tx_ready", a_tx_ready, 1'b0);
        p_reset = 1'b0;
        @(negedge p_clk);
        check("post_rst_tx_ready", a_tx_ready, 1'b1);
        check("post_rst_tx_ready_b", b_tx_ready, 1'b1);

        // Single byte 0xA5, loopback, timing
        use_flash = 1'b0;
        send_a(8'hA5, 1'b1, 8'h00, 1'b0, t);
        rises.delete();
        rxv_k = -1; rxv_n = 0; cs_k = -1; rdy_k = -1; lp = 1'b0; rxd = 8'h00;
        for (int i = 0; i < 45; i++) begin
            @(negedge p_clk);
            k = cyc - t;
            if (k == 1) begin
                check("a5_cs_low_t1", a_cs_n, 1'b0);
                check("a5_busy_t1", a_busy, 1'b1);
            end
            if (a_sck && !lp) rises.push_back(k);
            lp = a_sck;
            if (a_rx_valid) begin
                rxv_k = k;
                rxv_n++;
                rxd = a_rx_data;
            end
            if (a_cs_n && cs_k < 0) cs_k = k;
            if (a_tx_ready && rdy_k < 0) rdy_k = k;
        end
        check("a5_rise_count", rises.size(), 8);
        for (int i = 0; i < rises.size() && i < 8; i++) check("a5_rise_cycle", rises[i], 3 + 4 * i);
        check("a5_rx_valid_cycle", rxv_k, 35);
        check("a5_rx_valid_width", rxv_n, 1);
        check("a5_rx_data", rxd, 8'hA5);
        check("a5_cs_high_cycle", cs_k, 37);
        check("a5_tx_ready_cycle", rdy_k, 39);

        // Reset mid-byte
        send_a(8'h5A, 1'b0, 8'h00, 1'b0, t);
        v0 = rxv_count;
        n = 0; k = 0; lp = 1'b0;
        while (n < 4 && k < 100) begin
            @(negedge p_clk);
            if (a_sck && !lp) n++;
            lp = a_sck;
            k++;
        end
        check("midrst_reached_4th_rise", n, 4);
        p_reset = 1'b1;
        @(negedge p_clk);
        check("midrst_cs_n", a_cs_n, 1'b1);
        check("midrst_sck", a_sck, 1'b0);
        check("midrst_mosi", a_mosi, 1'b0);
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_rx_valid", a_rx_valid, 1'b0);
        check("midrst_tx_ready", a_tx_ready, 1'b0);
        exp_tx.delete();
        exp_rx.delete();
        p_reset = 1'b0;
        @(negedge p_clk);
        check("midrst_release_tx_ready", a_tx_ready, 1'b1);
        send_a(8'hC3, 1'b1, 8'h00, 1'b0, t);
        wait_idle_a("c3");
        check("midrst_rx_count", rxv_count - v0, 1);

        // Read command with flash model
        use_flash = 1'b1;
        r0 = total_rises;
        c0 = cs_rise_cnt;
        send_a(8'h03, 1'b0, 8'h00, 1'b0, t);
        send_a(8'h00, 1'b0, 8'h00, 1'b0, t);
        send_a(8'h10, 1'b0, 8'h00, 1'b0, t);
        send_a(8'h00, 1'b0, 8'h00, 1'b0, t);
        send_a(8'hFF, 1'b1, 8'h3C, 1'b0, t);
        check("read_cs_held_low", cs_rise_cnt - c0, 0);
        wait_idle_a("read");
        check("read_total_rises", total_rises - r0, 40);
        check("read_cs_release_once", cs_rise_cnt - c0, 1);
        use_flash = 1'b0;

        // Back-pressure in WAIT
        send_a(8'h11, 1'b0, 8'h00, 1'b0, t);
        n = 0;
        @(negedge p_clk);
        while (!a_tx_ready && n < 100) begin
            @(negedge p_clk);
            n++;
        end
        bp_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge p_clk);
            if (!(a_cs_n == 1'b0 && a_sck == 1'b0 && a_tx_ready == 1'b1)) bp_bad++;
        end
        check("bp_hold_state", bp_bad, 0);
        check("bp_mosi_bit0", a_mosi, 1'b1);
        send_a(8'h9F, 1'b1, 8'h00, 1'b0, t);
        wait_idle_a("bp");

        // tx_valid held high with changing data during the byte
        r0 = total_rises;
        c0 = cs_rise_cnt;
        send_a(8'h6B, 1'b1, 8'h00, 1'b1, t);
        for (int i = 0; i < 30; i++) begin
            @(negedge p_clk);
            a_tx_data = 8'($urandom);
            a_tx_last = 1'($urandom);
        end
        a_tx_valid = 1'b0;
        wait_idle_a("hold");
        check("hold_single_byte_rises", total_rises - r0, 8);
        check("hold_cs_release", cs_rise_cnt - c0, 1);

        // CLK_DIV=1 instance, MISO tied high
        n = 0;
        @(negedge p_clk);
        while (!b_tx_ready && n < 100) begin
            @(negedge p_clk);
            n++;
        end
        b_tx_data  = 8'h00;
        b_tx_last  = 1'b1;
        b_tx_valid = 1'b1;
        t = cyc;
        @(posedge p_clk);
        #1;
        b_tx_valid = 1'b0;
        rises.delete();
        rxv_k = -1; rxv_n = 0; cs_k = -1; rdy_k = -1; lp = 1'b0; rxd = 8'h00;
        for (int i = 0; i < 25; i++) begin
            @(negedge p_clk);
            k = cyc - t;
            if (b_sck && !lp) rises.push_back(k);
            lp = b_sck;
            if (b_rx_valid) begin
                rxv_k = k;
                rxv_n++;
                rxd = b_rx_data;
            end
            if (b_cs_n && cs_k < 0 && k > 1) cs_k = k;
            if (b_tx_ready && rdy_k < 0) rdy_k = k;
        end
        check("div1_rise_count", rises.size(), 8);
        for (int i = 0; i < rises.size() && i < 8; i++) check("div1_rise_cycle", rises[i], 2 + 2 * i);
        check("div1_rx_valid_cycle", rxv_k, 18);
        check("div1_rx_valid_width", rxv_n, 1);
        check("div1_rx_data", rxd, 8'hFF);
        check("div1_cs_high_cycle", cs_k, 19);
        check("div1_tx_ready_cycle", rdy_k, 20);

        // Final scoreboard state
        repeat (5) @(negedge p_clk);
        check("mosi_stable_while_sck_high", mosi_viol, 0);
        check("exp_tx_drained", exp_tx.size(), 0);
        check("exp_rx_drained", exp_rx.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
